instr_loader: RTL and testbench
===============================

# instr_loader

Instruction loader sitting directly upstream of the top-level accelerator FSM. On request it fetches instruction words from external DDR in bursts and writes them into the instruction memory, which it manages as a circular buffer. It also maintains occupancy and drives the `i_mem_empty` flag that the FSM polls; the FSM's read-enable pulse marks each instruction consumed.

## Interface
- `ADDR_W`, 10: instruction-memory address width; buffer depth `2**ADDR_W`.
- `DATA_W`, 64: instruction width.
- `DDR_ADDR_W`, 32: DDR byte-address width.
- `BURST_MAX`, 16: maximum beats per DDR read request.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle pulse; latches `base_addr` and `num_instr`, clears pointers. Honoured in IDLE only.
- `base_addr` in DDR_ADDR_W: DDR byte address of the first instruction.
- `num_instr` in 16: total instructions in the program.
- `fetch_req` in 1: level; FSM requests loading.
- `consume` in 1: pulse; one instruction read out of i_mem.
- `ddr_rd_req` out 1: read request, held until acknowledged.
- `ddr_rd_addr` out DDR_ADDR_W: burst start byte address.
- `ddr_rd_len` out 8: beats in the burst, 1..BURST_MAX.
- `ddr_rd_ack` in 1: request accepted.
- `ddr_rd_valid` in 1: data beat valid.
- `ddr_rd_data` in DATA_W: data beat.
- `imem_we` out 1: i_mem write strobe.
- `imem_waddr` out ADDR_W: write address.
- `imem_wdata` out DATA_W: write data.
- `i_mem_empty` out 1: occupancy == 0.
- `i_mem_full` out 1: occupancy == `2**ADDR_W`.
- `load_done` out 1: all `num_instr` words fetched; cleared by `start`.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, REQ, RECV.
- IDLE → REQ when `fetch_req` is high, `remaining > 0` and `free > 0`. Compute `len = min(BURST_MAX, remaining, free)`. Compute `addr = base_addr + fetched*(DATA_W/8)`, truncated to DDR_ADDR_W.
- REQ: assert `ddr_rd_req` with `addr` and `len` held stable. On `ddr_rd_ack`, deassert the request the next cycle and go to RECV.
- RECV, on each `ddr_rd_valid`:
  - register the beat: `imem_we` = 1 next cycle, `imem_waddr` = wptr;
  - wptr++ (wraps modulo `2**ADDR_W`); `fetched`++, `remaining`--, `beats`--.
  - When the last beat is taken: go to REQ if the IDLE→REQ condition still holds, else IDLE.
- Occupancy counter is ADDR_W+1 bits wide:
  - increments at the edge where a write commits;
  - decrements on `consume`;
  - simultaneous commit and consume leave it unchanged.
  - `consume` while empty is ignored and the count does not underflow.
- `free = 2**ADDR_W − occupancy − beats outstanding`. A burst never overruns unconsumed entries.
- `load_done` sets when `remaining` reaches 0. `num_instr` = 0 sets `load_done` on `start`, and no request is issued.
- `start` outside IDLE is ignored. `fetch_req` falling mid-burst does not abort; the burst completes.
- `ddr_rd_valid` outside RECV is dropped.

## Timing
- Reset values: `ddr_rd_req`=0, `ddr_rd_addr`=0, `ddr_rd_len`=0, `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0, `i_mem_empty`=1, `i_mem_full`=0, `load_done`=0, `busy`=0. State IDLE; pointers, counters and `remaining` are 0.
- Request latency: `ddr_rd_req` rises 1 cycle after the IDLE→REQ condition is met.
- Write latency: `imem_we` asserts 1 cycle after `ddr_rd_valid`.
- `i_mem_empty` falls 1 cycle after the first `imem_we`.
- `i_mem_empty` and `i_mem_full` are registered and reflect occupancy after each edge.
- Back-to-back beats sustain 1 word/cycle.
- `rst` mid-burst returns to IDLE immediately with all state cleared. Data beats still arriving from DDR after reset are dropped.

## Structure
- Shared package `tproc_pkg`: state encoding, `INSTR_W` = 64, DDR beat-width constant.
- One natural sub-module `occ_counter`: occupancy/empty/full logic with increment, decrement and simultaneous handling.

## Test plan
- Reset, then `start`, `base_addr`=0x1000, `num_instr`=5, `fetch_req`=1 → one request, addr 0x1000, len 5. Five writes to addresses 0..4. `load_done`=1, `i_mem_empty`=0.
- `num_instr`=40, BURST_MAX=16 → requests with len 16/16/8 at 0x1000/0x1080/0x1100. Last `imem_waddr` = 39.
- ADDR_W=3 (depth 8), `num_instr`=12, no `consume` → 8 words written, `i_mem_full`=1, no further request. Four `consume` pulses → request with len 4; writes wrap to addresses 0..3.
- `consume` on the same cycle as a write commit at occupancy 3 → occupancy stays 3. `consume` at occupancy 0 → stays 0, `i_mem_empty`=1.
- `rst` asserted after beat 2 of a 5-beat burst → all outputs return to reset values next cycle. Late `ddr_rd_valid` beats produce no `imem_we`.
- `start` with `num_instr`=0 → `load_done`=1, `ddr_rd_req` never asserts.

Source files
------------

// File: rtl/tproc_pkg.sv
// Shared definitions for the accelerator front end: instruction width, DDR beat size and
// the instruction-loader state encoding.
package tproc_pkg;

    localparam int unsigned INSTR_W        = 64;
    localparam int unsigned DDR_BEAT_BYTES = INSTR_W / 8;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRecv
    } ld_state_e;

    // Smallest of three candidate burst lengths, narrowed to the DDR length field.
    function automatic logic [7:0] min3_len(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] c);
        logic [31:0] m;
        m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        return 8'(m);
    endfunction

endpackage

// File: rtl/occ_counter.sv
// Instruction-memory occupancy tracker with registered empty/full flags.
module occ_counter #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    input  logic            dec,
    output logic [ADDR_W:0] occ,
    output logic            empty,
    output logic            full
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W:0] occ_q, occ_d;
    logic            empty_q, empty_d;
    logic            full_q, full_d;
    logic            dec_eff;

    // A read while empty has nothing to remove.
    assign dec_eff = dec && (occ_q != '0);

    always_comb begin
        occ_d = occ_q;
        if (clr) begin
            occ_d = '0;
        end else if (inc && !dec_eff) begin
            occ_d = occ_q + 1'b1;
        end else if (!inc && dec_eff) begin
            occ_d = occ_q - 1'b1;
        end
        empty_d = (occ_d == '0);
        full_d  = (occ_d == DEPTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    assign occ   = occ_q;
    assign empty = empty_q;
    assign full  = full_q;

endmodule

// File: rtl/instr_loader.sv
// Burst-fetches a program from DDR into the circular instruction memory, throttled by
// free space, and reports occupancy to the accelerator FSM.
module instr_loader
    import tproc_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = INSTR_W,
    parameter int unsigned DDR_ADDR_W = 32,
    parameter int unsigned BURST_MAX  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DDR_ADDR_W-1:0] base_addr,
    input  logic [15:0]           num_instr,
    input  logic                  fetch_req,
    input  logic                  consume,
    output logic                  ddr_rd_req,
    output logic [DDR_ADDR_W-1:0] ddr_rd_addr,
    output logic [7:0]            ddr_rd_len,
    input  logic                  ddr_rd_ack,
    input  logic                  ddr_rd_valid,
    input  logic [DATA_W-1:0]     ddr_rd_data,
    output logic                  imem_we,
    output logic [ADDR_W-1:0]     imem_waddr,
    output logic [DATA_W-1:0]     imem_wdata,
    output logic                  i_mem_empty,
    output logic                  i_mem_full,
    output logic                  load_done,
    output logic                  busy
);

    localparam int unsigned DEPTH      = 1 << ADDR_W;
    localparam int unsigned BEAT_BYTES = DATA_W / 8;

    ld_state_e             state_q, state_d;
    logic [DDR_ADDR_W-1:0] base_q, base_d;
    logic [15:0]           remaining_q, remaining_d;
    logic [15:0]           fetched_q, fetched_d;
    logic [ADDR_W-1:0]     wptr_q, wptr_d;
    logic [7:0]            beats_q, beats_d;
    logic                  req_q, req_d;
    logic [DDR_ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     waddr_q, waddr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  done_q, done_d;

    logic                  take;
    logic [15:0]           rem_n, fet_n;
    logic [7:0]            pend_n;
    logic [31:0]           free;
    logic                  can_launch, launch, occ_clr;
    logic [7:0]            burst_len;
    logic [DDR_ADDR_W-1:0] burst_addr;
    logic [ADDR_W:0]       occ;

    occ_counter #(
        .ADDR_W(ADDR_W)
    ) u_occ (
        .clk  (clk),
        .rst  (rst),
        .clr  (occ_clr),
        .inc  (we_q),
        .dec  (consume),
        .occ  (occ),
        .empty(i_mem_empty),
        .full (i_mem_full)
    );

    assign take   = (state_q == StRecv) && ddr_rd_valid;
    assign rem_n  = remaining_q - 16'(take);
    assign fet_n  = fetched_q + 16'(take);
    assign pend_n = beats_q - 8'(take);

    // Space not yet claimed: the pending write and every beat still owed by DDR are
    // already reserved, so a new burst can never overrun unconsumed entries.
    assign free = DEPTH - 32'(occ) - 32'(we_q) - 32'(beats_q);

    assign can_launch = fetch_req && (rem_n != '0) && (free != '0);
    assign burst_len  = min3_len(32'(BURST_MAX), 32'(rem_n), free);
    assign burst_addr = base_q + DDR_ADDR_W'(32'(fet_n) * BEAT_BYTES);

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        remaining_d = remaining_q;
        fetched_d   = fetched_q;
        wptr_d      = wptr_q;
        beats_d     = beats_q;
        req_d       = req_q;
        addr_d      = addr_q;
        len_d       = len_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        done_d      = done_q;
        launch      = 1'b0;
        occ_clr     = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    base_d      = base_addr;
                    remaining_d = num_instr;
                    fetched_d   = '0;
                    wptr_d      = '0;
                    done_d      = (num_instr == '0);
                    occ_clr     = 1'b1;
                end else if (can_launch) begin
                    launch = 1'b1;
                end
            end
            StReq: begin
                if (ddr_rd_ack) begin
                    req_d   = 1'b0;
                    state_d = StRecv;
                end
            end
            StRecv: begin
                if (ddr_rd_valid) begin
                    we_d        = 1'b1;
                    waddr_d     = wptr_q;
                    wdata_d     = ddr_rd_data;
                    wptr_d      = wptr_q + 1'b1;
                    fetched_d   = fet_n;
                    remaining_d = rem_n;
                    beats_d     = pend_n;
                    if (rem_n == '0) done_d = 1'b1;
                    if (pend_n == '0) begin
                        if (can_launch) launch = 1'b1;
                        else            state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (launch) begin
            state_d = StReq;
            req_d   = 1'b1;
            addr_d  = burst_addr;
            len_d   = burst_len;
            beats_d = burst_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            base_q      <= '0;
            remaining_q <= '0;
            fetched_q   <= '0;
            wptr_q      <= '0;
            beats_q     <= '0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            remaining_q <= remaining_d;
            fetched_q   <= fetched_d;
            wptr_q      <= wptr_d;
            beats_q     <= beats_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
        end
    end

    assign ddr_rd_req  = req_q;
    assign ddr_rd_addr = addr_q;
    assign ddr_rd_len  = len_q;
    assign imem_we     = we_q;
    assign imem_waddr  = waddr_q;
    assign imem_wdata  = wdata_q;
    assign load_done   = done_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a default-size instance and a depth-8 instance share
// the DDR-side stimulus; each is started separately.
module tb_instr_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_a, start_b, fetch_req, consume, ddr_rd_ack, ddr_rd_valid;
    logic [31:0] base_addr;
    logic [15:0] num_instr;
    logic [63:0] ddr_rd_data;

    logic        a_req, a_we, a_empty, a_full, a_done, a_busy;
    logic [31:0] a_addr;
    logic [7:0]  a_len;
    logic [9:0]  a_waddr;
    logic [63:0] a_wdata;

    logic        b_req, b_we, b_empty, b_full, b_done, b_busy;
    logic [31:0] b_addr;
    logic [7:0]  b_len;
    logic [2:0]  b_waddr;
    logic [63:0] b_wdata;

    instr_loader dut_a (
        .clk(clk), .rst(rst), .start(start_a), .base_addr(base_addr), .num_instr(num_instr),
        .fetch_req(fetch_req), .consume(consume), .ddr_rd_req(a_req), .ddr_rd_addr(a_addr),
        .ddr_rd_len(a_len), .ddr_rd_ack(ddr_rd_ack), .ddr_rd_valid(ddr_rd_valid),
        .ddr_rd_data(ddr_rd_data), .imem_we(a_we), .imem_waddr(a_waddr),
        .imem_wdata(a_wdata), .i_mem_empty(a_empty), .i_mem_full(a_full),
        .load_done(a_done), .busy(a_busy)
    );

    instr_loader #(.ADDR_W(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .base_addr(base_addr), .num_instr(num_instr),
        .fetch_req(fetch_req), .consume(consume), .ddr_rd_req(b_req), .ddr_rd_addr(b_addr),
        .ddr_rd_len(b_len), .ddr_rd_ack(ddr_rd_ack), .ddr_rd_valid(ddr_rd_valid),
        .ddr_rd_data(ddr_rd_data), .imem_we(b_we), .imem_waddr(b_waddr),
        .imem_wdata(b_wdata), .i_mem_empty(b_empty), .i_mem_full(b_full),
        .load_done(b_done), .busy(b_busy)
    );

    int checks = 0;
    int failures = 0;
    int beat_idx = 0;

    logic [15:0] wa_a[$];
    logic [63:0] wd_a[$];
    logic [15:0] wa_b[$];

    logic [31:0] exp_addr [3] = '{32'h1000, 32'h1080, 32'h1100};
    logic [7:0]  exp_len  [3] = '{8'd16, 8'd16, 8'd8};

    // Write log, sampled just after each active edge.
    always @(posedge clk) begin
        #1;
        if (a_we) begin
            wa_a.push_back(16'(a_waddr));
            wd_a.push_back(a_wdata);
        end
        if (b_we) wa_b.push_back(16'(b_waddr));
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        ddr_rd_ack = 1'b0;
        ddr_rd_valid = 1'b0;
        consume = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        beat_idx = 0;
    endtask

    task automatic do_start(input bit sel, input logic [31:0] base, input logic [15:0] num);
        base_addr = base;
        num_instr = num;
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic check_reset_a(input string p);
        chk({p, "_req"},   64'(a_req),   64'h0);
        chk({p, "_addr"},  64'(a_addr),  64'h0);
        chk({p, "_len"},   64'(a_len),   64'h0);
        chk({p, "_we"},    64'(a_we),    64'h0);
        chk({p, "_waddr"}, 64'(a_waddr), 64'h0);
        chk({p, "_wdata"}, a_wdata,      64'h0);
        chk({p, "_empty"}, 64'(a_empty), 64'h1);
        chk({p, "_full"},  64'(a_full),  64'h0);
        chk({p, "_done"},  64'(a_done),  64'h0);
        chk({p, "_busy"},  64'(a_busy),  64'h0);
    endtask

    // Wait for a request, acknowledge it and return its beats back-to-back.
    task automatic serve(input bit sel, input int cons_beat,
                         output logic [31:0] addr, output logic [7:0] len);
        int n = 0;
        addr = '0;
        len = '0;
        while (!(sel ? b_req : a_req) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("req_timeout", 64'(sel ? b_req : a_req), 64'h1);
            return;
        end
        addr = sel ? b_addr : a_addr;
        len = sel ? b_len : a_len;
        ddr_rd_ack = 1'b1;
        @(negedge clk);
        ddr_rd_ack = 1'b0;
        for (int i = 0; i < int'(len); i++) begin
            ddr_rd_valid = 1'b1;
            ddr_rd_data = {32'hC0DE_0000, 32'(beat_idx)};
            beat_idx++;
            consume = (i == cons_beat);
            @(negedge clk);
        end
        ddr_rd_valid = 1'b0;
        consume = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        logic [7:0]  len;
        logic        req_seen;

        rst = 1'b1;
        fetch_req = 1'b0;
        base_addr = '0;
        num_instr = '0;
        ddr_rd_data = '0;
        do_reset();
        check_reset_a("rst");

        // Single short program.
        fetch_req = 1'b1;
        wa_a.delete();
        wd_a.delete();
        do_start(1'b0, 32'h1000, 16'd5);
        chk("t1_req_lat0", 64'(a_req), 64'h0);
        @(negedge clk);
        chk("t1_req_lat1", 64'(a_req), 64'h1);
        serve(1'b0, -1, addr, len);
        chk("t1_addr", 64'(addr), 64'h1000);
        chk("t1_len", 64'(len), 64'h5);
        repeat (3) @(negedge clk);
        chk("t1_nwr", 64'(wa_a.size()), 64'h5);
        for (int i = 0; i < 5; i++) begin
            chk("t1_waddr", 64'(wa_a[i]), 64'(i));
            chk("t1_wdata", wd_a[i], {32'hC0DE_0000, 32'(i)});
        end
        chk("t1_done", 64'(a_done), 64'h1);
        chk("t1_empty", 64'(a_empty), 64'h0);
        chk("t1_req_idle", 64'(a_req), 64'h0);
        chk("t1_busy", 64'(a_busy), 64'h0);

        // Three bursts capped at BURST_MAX.
        do_reset();
        wa_a.delete();
        do_start(1'b0, 32'h1000, 16'd40);
        for (int b = 0; b < 3; b++) begin
            serve(1'b0, -1, addr, len);
            chk("t2_addr", 64'(addr), 64'(exp_addr[b]));
            chk("t2_len", 64'(len), 64'(exp_len[b]));
        end
        repeat (3) @(negedge clk);
        chk("t2_nwr", 64'(wa_a.size()), 64'd40);
        chk("t2_last_waddr", 64'(wa_a[wa_a.size() - 1]), 64'd39);
        chk("t2_done", 64'(a_done), 64'h1);

        // Depth-8 buffer fills, stalls, then wraps after consumption.
        do_reset();
        wa_b.delete();
        do_start(1'b1, 32'h1000, 16'd12);
        serve(1'b1, -1, addr, len);
        chk("t3_addr0", 64'(addr), 64'h1000);
        chk("t3_len0", 64'(len), 64'h8);
        req_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (b_req) req_seen = 1'b1;
        end
        chk("t3_no_req_full", 64'(req_seen), 64'h0);
        chk("t3_full", 64'(b_full), 64'h1);
        chk("t3_nwr0", 64'(wa_b.size()), 64'h8);
        fetch_req = 1'b0;
        repeat (4) begin
            consume = 1'b1;
            @(negedge clk);
            consume = 1'b0;
            @(negedge clk);
        end
        chk("t3_not_full", 64'(b_full), 64'h0);
        fetch_req = 1'b1;
        serve(1'b1, -1, addr, len);
        chk("t3_addr1", 64'(addr), 64'h1040);
        chk("t3_len1", 64'(len), 64'h4);
        repeat (3) @(negedge clk);
        chk("t3_nwr1", 64'(wa_b.size()), 64'd12);
        for (int i = 0; i < 4; i++) chk("t3_wrap_waddr", 64'(wa_b[8 + i]), 64'(i));
        chk("t3_full_again", 64'(b_full), 64'h1);
        chk("t3_done", 64'(b_done), 64'h1);

        // Consume colliding with a commit, then consume while empty.
        do_reset();
        do_start(1'b1, 32'h2000, 16'd5);
        serve(1'b1, 4, addr, len);
        chk("t4_len", 64'(len), 64'h5);
        chk("t4_occ_simul", 64'(dut_b.u_occ.occ), 64'h3);
        @(negedge clk);
        chk("t4_occ_last", 64'(dut_b.u_occ.occ), 64'h4);
        consume = 1'b1;
        repeat (5) @(negedge clk);
        consume = 1'b0;
        chk("t4_occ_floor", 64'(dut_b.u_occ.occ), 64'h0);
        chk("t4_empty", 64'(b_empty), 64'h1);

        // Reset during a burst; late beats must be dropped.
        do_reset();
        wa_a.delete();
        do_start(1'b0, 32'h1000, 16'd5);
        @(negedge clk);
        chk("t5_req", 64'(a_req), 64'h1);
        ddr_rd_ack = 1'b1;
        @(negedge clk);
        ddr_rd_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ddr_rd_valid = 1'b1;
            ddr_rd_data = {32'hC0DE_0000, 32'(i)};
            @(negedge clk);
        end
        rst = 1'b1;
        ddr_rd_data = {32'hC0DE_0000, 32'd2};
        @(negedge clk);
        check_reset_a("t5_rst");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        ddr_rd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_no_late_we", 64'(wa_a.size()), 64'h2);
        chk("t5_busy", 64'(a_busy), 64'h0);

        // Empty program.
        do_reset();
        do_start(1'b0, 32'h1000, 16'd0);
        chk("t6_done", 64'(a_done), 64'h1);
        req_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (a_req) req_seen = 1'b1;
        end
        chk("t6_no_req", 64'(req_seen), 64'h0);
        chk("t6_busy", 64'(a_busy), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
